axis_blinky_array: RTL

AXIS_BLINKY_ARRAY -- requirements
Module: axis_blinky_array

---
 rtl/axis_blinky_pkg.sv | 14 +
 rtl/blinky_channel.sv | 92 +++++++++
 rtl/axis_blinky_array.sv | 74 +++++++
 3 files changed

// File: rtl/axis_blinky_pkg.sv
// Shared definitions for the AXI-Stream configured LED blinker array.
// Mode encoding matches the s_axis_tuser field directly.
package axis_blinky_pkg;

  localparam int TUSER_W = 2;

  typedef enum logic [TUSER_W-1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } mode_e;

endpackage

// File: rtl/blinky_channel.sv
// One LED channel: mode, period register, half-period counter and output flop.
// A load always wins over counting, so it takes effect even while ce is low.
module blinky_channel
  import axis_blinky_pkg::*;
#(
  parameter int                   CNT_WIDTH  = 32,
  parameter logic [CNT_WIDTH-1:0] RST_PERIOD = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 ld,
  input  mode_e                ld_mode,
  input  logic [CNT_WIDTH-1:0] ld_period,
  output logic                 q
);

  mode_e                mode_q, mode_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 q_q, q_d;
  logic [CNT_WIDTH-1:0] lim;
  logic                 last;

  always_comb begin
    // A zero period behaves like a period of one.
    lim  = (period_q == '0) ? '0 : period_q - CNT_WIDTH'(1);
    last = (cnt_q == lim);

    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    q_d      = q_q;

    if (ld) begin
      mode_d   = ld_mode;
      period_d = ld_period;
      cnt_d    = '0;
      q_d      = (ld_mode != MODE_OFF);
    end else if (ce) begin
      case (mode_q)
        MODE_OFF: begin
          cnt_d = '0;
          q_d   = 1'b0;
        end
        MODE_ON: begin
          cnt_d = '0;
          q_d   = 1'b1;
        end
        MODE_BLINK: begin
          if (last) begin
            cnt_d = '0;
            q_d   = ~q_q;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        MODE_PULSE: begin
          if (last) begin
            mode_d = MODE_OFF;
            cnt_d  = '0;
            q_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          mode_d = MODE_OFF;
          cnt_d  = '0;
          q_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_BLINK;
      period_q <= RST_PERIOD;
      cnt_q    <= '0;
      q_q      <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/axis_blinky_array.sv
// Array of independently configured LED channels fed by an AXI-Stream config port.
// tdest selects the channel, tuser the mode and tdata the period / pulse length.
module axis_blinky_array
  import axis_blinky_pkg::*;
#(
  parameter int  CLK_FREQ_HZ = 125_000_000,
  parameter int  NUM_CH      = 4,
  parameter int  CNT_WIDTH   = 32,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [CNT_WIDTH-1:0] s_axis_tdata,
  input  logic [CH_W-1:0]      s_axis_tdest,
  input  logic [TUSER_W-1:0]   s_axis_tuser,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [NUM_CH-1:0]    q,
  output logic                 cfg_err
);

  localparam logic [CH_W:0]      NUM_CH_L   = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(CLK_FREQ_HZ / 2);

  logic arm_q, arm_d;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic xfer;
  logic dest_ok;

  // Ready comes up two edges after reset drops, via the arm flop.
  always_comb begin
    xfer    = s_axis_tvalid && ready_q;
    dest_ok = ({1'b0, s_axis_tdest} < NUM_CH_L);
    arm_d   = 1'b1;
    ready_d = arm_q;
    err_d   = xfer && !dest_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign cfg_err       = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ld;
    assign ld = xfer && (s_axis_tdest == CH_W'(g));

    blinky_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .RST_PERIOD(RST_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .ld       (ld),
      .ld_mode  (mode_e'(s_axis_tuser)),
      .ld_period(s_axis_tdata),
      .q        (q[g])
    );
  end

endmodule
